// File: rtl/load_memory_decoder_if.sv
// Load decoder bus: memory word, load type/offset in; aligned result,
// exception and sticky fault out.
interface load_memory_decoder_if;
  logic [2:0]  type_;
  logic [1:0]  offset;
  logic [31:0] in;
  logic        valid;
  logic [31:0] out;
  logic        exception;
  logic        fault;

  modport master (
    output type_, offset, in, valid,
    input  out, exception, fault
  );

  modport slave (
    input  type_, offset, in, valid,
    output out, exception, fault
  );
endinterface

// File: rtl/load_memory_decoder.sv
// RV32I load aligner: byte/half/word select, sign/zero extend, sticky fault.
// Define LOAD_DECODER_REG_OUT_EN to register out/exception (1-cycle latency).
module load_memory_decoder (
  input logic                  clk,
  input logic                  rst,
  load_memory_decoder_if.slave bus
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] out_c;
  logic        exc_c;
  logic        flt_set;
  logic        is_lb, is_lh, is_lw;
  logic        is_lbu, is_lhu;

  // Lane muxes keep unselected bytes out of the result.
  always_comb begin
    b = 8'h00;
    h = 16'h0000;
    unique case (bus.offset)
      2'd0: begin
        b = bus.in[7:0];
        h = bus.in[15:0];
      end
      2'd1: begin
        b = bus.in[15:8];
        h = bus.in[23:8];
      end
      2'd2: begin
        b = bus.in[23:16];
        h = bus.in[31:16];
      end
      2'd3: begin
        b = bus.in[31:24];
        h = 16'h0000;
      end
    endcase
  end

  assign is_lb  = bus.type_ == 3'b000;
  assign is_lh  = bus.type_ == 3'b001;
  assign is_lw  = bus.type_ == 3'b010;
  assign is_lbu = bus.type_ == 3'b100;
  assign is_lhu = bus.type_ == 3'b101;

  always_comb begin
    out_c = 32'h0;
    exc_c = 1'b0;
    unique case (1'b1)
      is_lb:  out_c = {{24{b[7]}}, b};
      is_lbu: out_c = {24'h0, b};
      is_lh: begin
        if (bus.offset == 2'd3) exc_c = 1'b1;
        else out_c = {{16{h[15]}}, h};
      end
      is_lhu: begin
        if (bus.offset == 2'd3) exc_c = 1'b1;
        else out_c = {16'h0, h};
      end
      is_lw: begin
        if (bus.offset != 2'd0) exc_c = 1'b1;
        else out_c = bus.in;
      end
      default: exc_c = 1'b1;
    endcase
  end

`ifdef LOAD_DECODER_REG_OUT_EN
  logic [31:0] out_q;
  logic        exc_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 32'h0;
      exc_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_c;
      exc_q   <= exc_c;
      valid_q <= bus.valid;
    end
  end

  assign bus.out       = out_q;
  assign bus.exception = exc_q;
  assign flt_set       = valid_q & exc_q;
`else
  assign bus.out       = out_c;
  assign bus.exception = exc_c;
  assign flt_set       = bus.valid & exc_c;
`endif

  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_q | flt_set;
  end

  assign bus.fault = fault_q;

endmodule

// File: tb/tb_load_memory_decoder.sv
// Directed bench for load_memory_decoder; results sampled #1 after an edge
// so the same vectors hold with or without the registered output option.
module tb_load_memory_decoder;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  load_memory_decoder_if bus ();

  load_memory_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [2:0] t,
                     input logic [1:0] off, input logic [31:0] din,
                     input logic [31:0] eo, input logic ee);
    bus.type_  = t;
    bus.offset = off;
    bus.in     = din;
    step();
    chk({tag, ".out"}, bus.out, eo);
    chk({tag, ".exc"}, {31'h0, bus.exception}, {31'h0, ee});
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bus.valid  = 1'b0;
    bus.type_  = 3'b010;
    bus.offset = 2'd0;
    bus.in     = 32'h0;
    step();
    step();
    chk("rst.fault", {31'h0, bus.fault}, 32'h0);
    rst = 1'b0;

    vec("lb2",   3'b000, 2'd2, 32'hxxbfxxxx, 32'hffffffbf, 1'b0);
    vec("lh1",   3'b001, 2'd1, 32'hxxbfffxx, 32'hffffbfff, 1'b0);
    vec("lhu2",  3'b101, 2'd2, 32'hffffxxxx, 32'h0000ffff, 1'b0);
    vec("lbu3",  3'b100, 2'd3, 32'hffxxxxxx, 32'h000000ff, 1'b0);
    vec("lw0",   3'b010, 2'd0, 32'hffffffff, 32'hffffffff, 1'b0);
    vec("lb0",   3'b000, 2'd0, 32'h12345680, 32'hffffff80, 1'b0);
    vec("lb1",   3'b000, 2'd1, 32'h12347f00, 32'h0000007f, 1'b0);
    vec("lbu1",  3'b100, 2'd1, 32'h0000a500, 32'h000000a5, 1'b0);
    vec("lh0",   3'b001, 2'd0, 32'hxxxx8001, 32'hffff8001, 1'b0);
    vec("lh2",   3'b001, 2'd2, 32'h7fffxxxx, 32'h00007fff, 1'b0);
    vec("lhu0",  3'b101, 2'd0, 32'hxxxx8000, 32'h00008000, 1'b0);
    vec("lhu1",  3'b101, 2'd1, 32'hxx9abcxx, 32'h00009abc, 1'b0);
    vec("lw0b",  3'b010, 2'd0, 32'hdeadbeef, 32'hdeadbeef, 1'b0);
    vec("lh3",   3'b001, 2'd3, 32'hxxxxxxxx, 32'h00000000, 1'b1);
    vec("lhu3",  3'b101, 2'd3, 32'hffffffff, 32'h00000000, 1'b1);
    vec("lw1",   3'b010, 2'd1, 32'hxxxxxxxx, 32'h00000000, 1'b1);
    vec("lw2",   3'b010, 2'd2, 32'hffffffff, 32'h00000000, 1'b1);
    vec("lw3",   3'b010, 2'd3, 32'hffffffff, 32'h00000000, 1'b1);
    vec("t011",  3'b011, 2'd0, 32'hxxxxxxxx, 32'h00000000, 1'b1);
    vec("t110",  3'b110, 2'd0, 32'hffffffff, 32'h00000000, 1'b1);
    vec("t111",  3'b111, 2'd2, 32'hffffffff, 32'h00000000, 1'b1);
    chk("novalid.fault", {31'h0, bus.fault}, 32'h0);

    bus.valid  = 1'b1;
    bus.type_  = 3'b010;
    bus.offset = 2'd0;
    step();
    step();
    chk("okvalid.fault", {31'h0, bus.fault}, 32'h0);

    bus.offset = 2'd1;
    step();
    bus.valid  = 1'b0;
    bus.offset = 2'd0;
    step();
    chk("set.fault", {31'h0, bus.fault}, 32'h1);
    for (int i = 0; i < 3; i++) step();
    chk("hold.fault", {31'h0, bus.fault}, 32'h1);

    rst        = 1'b1;
    bus.valid  = 1'b1;
    bus.type_  = 3'b111;
    step();
    chk("rstwin.fault", {31'h0, bus.fault}, 32'h0);
    bus.valid  = 1'b0;
    bus.type_  = 3'b010;
    step();
    rst = 1'b0;
    step();
    step();
    chk("clr.fault", {31'h0, bus.fault}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
